// File: rtl/deserializer_pkg.sv
// Shared sizing constants for the serializer/deserializer pair.
package deserializer_pkg;
    localparam int INPUT_SIZE  = 4;
    localparam int OUTPUT_SIZE = 32;
    localparam int BEATS       = OUTPUT_SIZE / INPUT_SIZE;
    localparam int CNT_W       = $clog2(BEATS);
endpackage

// File: rtl/deserializer_sipo_shift_register.sv
// Serial-in parallel-out collect register; beats enter at the LSB end so the
// first beat of a word migrates to the MSB end.
module sipo_shift_register
    import deserializer_pkg::*;
#(
    parameter int INPUT_SIZE  = deserializer_pkg::INPUT_SIZE,
    parameter int OUTPUT_SIZE = deserializer_pkg::OUTPUT_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic [INPUT_SIZE-1:0]  data_in,
    output logic [OUTPUT_SIZE-1:0] data_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (shift_en) begin
            data_out <= {data_out[OUTPUT_SIZE-INPUT_SIZE-1:0], data_in};
        end
    end

endmodule

// File: rtl/deserializer.sv
// Assembles serial beats into words with one word of output buffering,
// FIFO backpressure and a sticky overflow flag for dropped words.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int INPUT_SIZE  = deserializer_pkg::INPUT_SIZE,
    parameter int OUTPUT_SIZE = deserializer_pkg::OUTPUT_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_SIZE-1:0]  data_in,
    input  logic                   data_valid,
    input  logic                   fifo_full,
    input  logic                   clear_overflow,
    output logic [OUTPUT_SIZE-1:0] data_out,
    output logic                   write_fifo,
    output logic                   deserializer_idle,
    output logic                   overflow
);

    localparam int NBEATS = OUTPUT_SIZE / INPUT_SIZE;
    localparam int NCNT_W = $clog2(NBEATS);

    logic [NCNT_W-1:0]      counter;
    logic [OUTPUT_SIZE-1:0] collect;
    logic                   pending;
    logic                   last_beat;
    logic                   word_drop;

    sipo_shift_register #(
        .INPUT_SIZE  (INPUT_SIZE),
        .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .shift_en (data_valid),
        .data_in  (data_in),
        .data_out (collect)
    );

    assign last_beat         = data_valid && (counter == NCNT_W'(NBEATS - 1));
    assign write_fifo        = pending && !fifo_full;
    // A completed word can only land if the buffer is empty or draining now.
    assign word_drop         = last_beat && pending && !write_fifo;
    assign deserializer_idle = (counter == '0) && !pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (data_valid) begin
            counter <= last_beat ? '0 : counter + NCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            pending  <= 1'b0;
        end else if (last_beat && !word_drop) begin
            data_out <= {collect[OUTPUT_SIZE-INPUT_SIZE-1:0], data_in};
            pending  <= 1'b1;
        end else if (write_fifo) begin
            pending  <= 1'b0;
        end
    end

    // Set has priority over clear so a same-edge drop is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (word_drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed and randomized checks of deserializer against a beat-list reference model.
module tb_deserializer;

    localparam int IW = 4;
    localparam int OW = 32;
    localparam int NB = OW / IW;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] data_in;
    logic          data_valid;
    logic          fifo_full;
    logic          clear_overflow;
    logic [OW-1:0] data_out;
    logic          write_fifo;
    logic          deserializer_idle;
    logic          overflow;

    int vectors = 0;
    int errors  = 0;

    logic [IW-1:0] m_beats[$];
    logic [OW-1:0] m_out;
    logic          m_pending;
    logic          m_ovf;
    logic [OW-1:0] got[$];

    deserializer #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) dut (
        .clk               (clk),
        .reset             (reset),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .fifo_full         (fifo_full),
        .clear_overflow    (clear_overflow),
        .data_out          (data_out),
        .write_fifo        (write_fifo),
        .deserializer_idle (deserializer_idle),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_out     = '0;
        m_pending = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check before posedge, advance model after it.
    task automatic step(input logic v, input logic [IW-1:0] d, input logic f, input logic c);
        logic          wr;
        logic          done;
        logic [OW-1:0] word;
        @(negedge clk);
        data_valid = v; data_in = d; fifo_full = f; clear_overflow = c;
        #1;
        wr = m_pending && !f;
        chk("write_fifo", {31'b0, write_fifo}, {31'b0, wr});
        chk("data_out", data_out, m_out);
        chk("idle", {31'b0, deserializer_idle}, {31'b0, (m_beats.size() == 0) && !m_pending});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        if (write_fifo === 1'b1) got.push_back(data_out);
        @(posedge clk);
        done = 1'b0;
        word = '0;
        if (v) begin
            m_beats.push_back(d);
            if (m_beats.size() == NB) begin
                done = 1'b1;
                foreach (m_beats[i]) word = word * (1 << IW) + OW'(m_beats[i]);
                m_beats.delete();
            end
        end
        if (done && m_pending && !wr) begin
            m_ovf = 1'b1;
        end else begin
            if (c) m_ovf = 1'b0;
            if (done) begin
                m_out = word;
                m_pending = 1'b1;
            end else if (wr) begin
                m_pending = 1'b0;
            end
        end
    endtask

    task automatic send_word(input logic [OW-1:0] w, input logic f);
        for (int i = NB - 1; i >= 0; i--) step(1'b1, w[i*IW +: IW], f, 1'b0);
    endtask

    task automatic idle_cycles(input int n, input logic f);
        for (int i = 0; i < n; i++) step(1'b0, '0, f, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        data_valid = 1'b0; fifo_full = 1'b0; clear_overflow = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_data_out", data_out, '0);
        chk("rst_write_fifo", {31'b0, write_fifo}, '0);
        chk("rst_idle", {31'b0, deserializer_idle}, 32'd1);
        chk("rst_overflow", {31'b0, overflow}, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] w;
        reset = 1'b1; data_in = '0; data_valid = 1'b0; fifo_full = 1'b0; clear_overflow = 1'b0;
        model_reset();
        #2;
        chk("init_idle", {31'b0, deserializer_idle}, 32'd1);
        chk("init_data_out", data_out, '0);
        @(negedge clk);
        reset = 1'b0;

        // Gap-free word, single write one cycle after beat 8
        got.delete();
        send_word(32'h12345678, 1'b0);
        idle_cycles(3, 1'b0);
        chk("w1_count", got.size(), 32'd1);
        if (got.size() > 0) chk("w1_word", got[0], 32'h12345678);

        // Backpressure hold for 5 cycles
        got.delete();
        send_word(32'h12345678, 1'b0);
        idle_cycles(5, 1'b1);
        chk("bp_held", data_out, 32'h12345678);
        chk("bp_none", got.size(), 32'd0);
        idle_cycles(3, 1'b0);
        chk("bp_count", got.size(), 32'd1);

        // Overflow: second word completes while first still blocked
        got.delete();
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'hCAFEF00D, 1'b1);
        idle_cycles(1, 1'b1);
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        chk("ovf_hold", data_out, 32'hDEADBEEF);
        idle_cycles(3, 1'b0);
        chk("ovf_count", got.size(), 32'd1);
        if (got.size() > 0) chk("ovf_word", got[0], 32'hDEADBEEF);
        step(1'b0, '0, 1'b0, 1'b1);
        idle_cycles(1, 1'b0);
        chk("ovf_clear", {31'b0, overflow}, 32'd0);

        // Completion on the same edge as the write
        got.delete();
        send_word(32'h0BADF00D, 1'b1);
        w = 32'h600DCAFE;
        for (int i = NB - 1; i >= 1; i--) step(1'b1, w[i*IW +: IW], 1'b1, 1'b0);
        step(1'b1, w[3:0], 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        chk("same_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("same_w0", got[0], 32'h0BADF00D);
            chk("same_w1", got[1], 32'h600DCAFE);
        end
        chk("same_ovf", {31'b0, overflow}, 32'd0);

        // Reset mid-word discards the partial beats
        got.delete();
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        do_reset();
        send_word(32'hABCDEF01, 1'b0);
        idle_cycles(3, 1'b0);
        chk("rst_count", got.size(), 32'd1);
        if (got.size() > 0) chk("rst_word", got[0], 32'hABCDEF01);

        // Random gaps between beats
        got.delete();
        w = 32'h12345678;
        for (int i = NB - 1; i >= 0; i--) begin
            idle_cycles(int'($urandom_range(0, 3)), 1'b0);
            step(1'b1, w[i*IW +: IW], 1'b0, 1'b0);
        end
        idle_cycles(3, 1'b0);
        chk("gap_count", got.size(), 32'd1);
        if (got.size() > 0) chk("gap_word", got[0], 32'h12345678);

        // Fully random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0), IW'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
